// File: rtl/axi_lite_reg_responder_if.sv
// AXI4-Lite bus bundle between a configuration master and the register
// responder. Carries the five AXI4-Lite channels (AW, W, B, AR, R).
// Clock and reset are not part of the bundle; they stay scalar ports on the
// modules that use it.
//   master modport : drives AW/W/AR payload + VALID, BREADY, RREADY
//   slave  modport : drives AWREADY, WREADY, B payload + VALID, ARREADY,
//                    R payload + VALID
interface axi_lite_reg_responder_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder holding four read/write registers.
// Ports:
//   ACLK, ARESET  : clock, synchronous active-high reset
//   s_axi         : AXI4-Lite slave bus (AW/W/B/AR/R)
//   reg_out       : {reg3,reg2,reg1,reg0}
//   reg_wr_stb    : one-cycle pulse per register on each committed write
// Byte address decode: index = addr[3:2], addr[1:0] ignored, any upper bit
// set (0x10..0x1F) is an invalid address answered with SLVERR.
module axi_lite_reg_responder #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi_lite_reg_responder_if.slave s_axi,
    output logic [4*DATA_WIDTH-1:0] reg_out,
    output logic [3:0]              reg_wr_stb
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [3:0][DATA_WIDTH-1:0] regs;
    logic [1:0]                 rdy_sr;   // READY held off for reset + 1 cycle
    logic                       rdy_en;

    logic                  aw_full, w_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NB-1:0]         w_strb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic awready, wready, arready, bvalid, rvalid, commit;
    logic aw_hs, w_hs, ar_hs;
    logic aw_invalid, ar_invalid;

    assign rdy_en     = rdy_sr[1];
    assign aw_hs      = s_axi.S_AXI_AWVALID & awready;
    assign w_hs       = s_axi.S_AXI_WVALID & wready;
    assign ar_hs      = s_axi.S_AXI_ARVALID & arready;
    assign aw_invalid = |aw_addr_q[ADDR_WIDTH-1:4];
    assign ar_invalid = |s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:4];

    always_ff @(posedge ACLK) begin
        if (ARESET) rdy_sr <= '0;
        else        rdy_sr <= {rdy_sr[0], 1'b1};
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   if ((aw_full | aw_hs) & (w_full | w_hs)) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_comb begin
        bvalid  = (w_state == W_RESP);
        commit  = (w_state == W_COMMIT);
        // Buffers stay full through W_COMMIT, so READY only needs BVALID beyond that.
        awready = rdy_en & ~aw_full & ~bvalid;
        wready  = rdy_en & ~w_full & ~bvalid;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            regs       <= '0;
            reg_wr_stb <= '0;
        end else begin
            reg_wr_stb <= '0;
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s_axi.S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi.S_AXI_WDATA;
                w_strb_q <= s_axi.S_AXI_WSTRB;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                if (aw_invalid) begin
                    bresp_q <= RESP_SLVERR;
                end else begin
                    bresp_q <= RESP_OKAY;
                    // Strobe pulses even for WSTRB=0: the write still happened.
                    reg_wr_stb[aw_addr_q[3:2]] <= 1'b1;
                    for (int b = 0; b < NB; b++)
                        if (w_strb_q[b])
                            regs[aw_addr_q[3:2]][b*8 +: 8] <= w_data_q[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = rdy_en & (r_state == R_IDLE);
        rvalid  = (r_state == R_RESP);
    end

    // Reads sample regs with the same edge a commit would update them, so a
    // colliding read naturally returns the pre-write value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= ar_invalid ? '0 : regs[s_axi.S_AXI_ARADDR[3:2]];
            rresp_q <= ar_invalid ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign reg_out             = regs;

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           aw_addr_q[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Randomized self-checking bench for axi_lite_reg_responder. A plain array
// of four words models the register file; expected responses, strobes and
// reg_out come from that model.
module tb_axi_lite_reg_responder;
    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_stb;

    always #5 ACLK = ~ACLK;

    axi_lite_reg_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus();

    axi_lite_reg_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(bus),
        .reg_out(reg_out), .reg_wr_stb(reg_wr_stb)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required summary before limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 5'd16)
            for (int b = 0; b < 4; b++)
                if (s[b]) m[a[3:2]][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic logic [127:0] model_out();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    function automatic logic [3:0] exp_stb(input logic [4:0] a);
        return (a < 5'd16) ? (4'b0001 << a[3:2]) : 4'b0000;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [4:0] a);
        return (a < 5'd16) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        return (a < 5'd16) ? m[a[3:2]] : 32'h0;
    endfunction

    // ---------------- bus drivers (called at a negedge, return at a negedge) ----------------
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output bit ok, output int lat, output logic [1:0] resp,
                            output logic [3:0] stb_b, output logic [127:0] ro_b,
                            output logic [3:0] stb_after, output logic bv_after);
        bit awp, wp, haw, hw;
        int cnt;
        ok = 1'b0; lat = -1; resp = 'x; stb_b = 'x; ro_b = 'x; stb_after = 'x; bv_after = 'x;
        bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
        awp = 1'b1; wp = 1'b1; cnt = 0;
        while ((awp || wp) && cnt < 50) begin
            haw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            hw  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(negedge ACLK); cnt++;
            if (haw) begin bus.S_AXI_AWVALID = 1'b0; awp = 1'b0; end
            if (hw)  begin bus.S_AXI_WVALID = 1'b0;  wp = 1'b0;  end
        end
        if (awp || wp) begin
            bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
            return;
        end
        lat = 0;
        while (!bus.S_AXI_BVALID && lat < 50) begin @(negedge ACLK); lat++; end
        if (!bus.S_AXI_BVALID) return;
        resp = bus.S_AXI_BRESP; stb_b = reg_wr_stb; ro_b = reg_out;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_BREADY = 1'b0;
        stb_after = reg_wr_stb; bv_after = bus.S_AXI_BVALID;
        ok = 1'b1;
    endtask

    task automatic do_read(input logic [4:0] a, output bit ok, output int lat,
                           output logic [31:0] data, output logic [1:0] resp, output logic rv_after);
        int cnt;
        bit h;
        ok = 1'b0; lat = -1; data = 'x; resp = 'x; rv_after = 'x;
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
        h = 1'b0; cnt = 0;
        while (!h && cnt < 50) begin
            h = bus.S_AXI_ARREADY;
            @(negedge ACLK); cnt++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        if (!h) return;
        lat = 0;
        while (!bus.S_AXI_RVALID && lat < 50) begin @(negedge ACLK); lat++; end
        if (!bus.S_AXI_RVALID) return;
        data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_RREADY = 1'b0;
        rv_after = bus.S_AXI_RVALID;
        ok = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [2:0] rdy;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        ARESET = 1'b1;
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        repeat (3) @(negedge ACLK);
        n_cmp++;
        if ({reg_out, reg_wr_stb, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RDATA,
             bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
             bus.S_AXI_ARREADY} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: reg_out=%h stb=%b bv=%b rv=%b rdata=%h rdy=%b%b%b, required all 0",
                     reg_out, reg_wr_stb, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RDATA,
                     bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
        rdy = {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY};
        n_cmp++;
        if (rdy !== 3'b000) begin
            n_err++; $display("FAIL ready_first_cycle: got %b required 000", rdy);
        end
        @(negedge ACLK);
        rdy = {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY};
        n_cmp++;
        if (rdy !== 3'b111) begin
            n_err++; $display("FAIL ready_second_edge: got %b required 111", rdy);
        end
    endtask

    task automatic test_seq_writes();
        bit ok; int lat; logic [1:0] resp; logic [3:0] sb, sa; logic [127:0] ro; logic bva, rva;
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] a;
            a = 5'(i * 4);
            do_write(a, 32'(i + 1), 4'hF, ok, lat, resp, sb, ro, sa, bva);
            model_write(a, 32'(i + 1), 4'hF);
            n_cmp++;
            if ({ok, lat, resp, sb, ro, sa, bva} !== {1'b1, 32'sd1, 2'b00, exp_stb(a), model_out(), 4'b0000, 1'b0}) begin
                n_err++;
                $display("FAIL seq_write[%0d]: ok=%b lat=%0d resp=%b stb=%b reg_out=%h stb_after=%b bv_after=%b, required ok=1 lat=1 resp=00 stb=%b reg_out=%h",
                         i, ok, lat, resp, sb, ro, sa, bva, exp_stb(a), model_out());
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(5'(i * 4), ok, lat, rd, resp, rva);
            n_cmp++;
            if ({ok, lat, rd, resp, rva} !== {1'b1, 32'sd0, 32'(i + 1), 2'b00, 1'b0}) begin
                n_err++;
                $display("FAIL seq_read[%0d]: ok=%b lat=%0d rdata=%h resp=%b rv_after=%b, required rdata=%h resp=00 lat=0",
                         i, ok, lat, rd, resp, rva, i + 1);
            end
        end
        n_cmp++;
        if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
            n_err++; $display("FAIL seq_reg_out: got %h required 00000004000000030000000200000001", reg_out);
        end
    endtask

    task automatic test_strobe();
        bit ok; int lat; logic [1:0] resp; logic [3:0] sb, sa; logic [127:0] ro; logic bva, rva;
        logic [31:0] rd;
        do_write(5'h04, 32'hAABBCCDD, 4'hF, ok, lat, resp, sb, ro, sa, bva);
        model_write(5'h04, 32'hAABBCCDD, 4'hF);
        do_write(5'h04, 32'h11223344, 4'b0101, ok, lat, resp, sb, ro, sa, bva);
        model_write(5'h04, 32'h11223344, 4'b0101);
        n_cmp++;
        if ({ok, resp, sb, sa} !== {1'b1, 2'b00, 4'b0010, 4'b0000}) begin
            n_err++; $display("FAIL strobe_write: ok=%b resp=%b stb=%b stb_after=%b, required resp=00 stb=0010 stb_after=0000", ok, resp, sb, sa);
        end
        do_read(5'h04, ok, lat, rd, resp, rva);
        n_cmp++;
        if ({ok, rd, resp} !== {1'b1, 32'hAA22CC44, 2'b00}) begin
            n_err++; $display("FAIL strobe_read: rdata=%h resp=%b, required AA22CC44 resp=00", rd, resp);
        end
        // Empty strobe: still a committed write with a strobe pulse, no data change.
        do_write(5'h05, 32'hFFFFFFFF, 4'b0000, ok, lat, resp, sb, ro, sa, bva);
        n_cmp++;
        if ({ok, resp, sb, ro} !== {1'b1, 2'b00, 4'b0010, model_out()}) begin
            n_err++; $display("FAIL wstrb_zero: resp=%b stb=%b reg_out=%h, required resp=00 stb=0010 reg_out=%h", resp, sb, ro, model_out());
        end
    endtask

    task automatic test_w_before_aw();
        int bad;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_WDATA = 32'hC0DE0003; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_WVALID = 1'b0;
        n_cmp++;
        if ({bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID} !== 3'b010) begin
            n_err++; $display("FAIL w_first_capture: wready=%b awready=%b bvalid=%b, required 0 1 0",
                              bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID);
        end
        repeat (2) @(negedge ACLK);
        bus.S_AXI_AWADDR = 5'h0C; bus.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        model_write(5'h0C, 32'hC0DE0003, 4'hF);
        n_cmp++;
        if (bus.S_AXI_BVALID !== 1'b0) begin
            n_err++; $display("FAIL w_first_bvalid_early: bvalid=%b required 0 on cycle of AW handshake", bus.S_AXI_BVALID);
        end
        @(negedge ACLK);
        n_cmp++;
        if ({bus.S_AXI_BVALID, reg_wr_stb, reg_out} !== {1'b1, 4'b1000, model_out()}) begin
            n_err++; $display("FAIL w_first_commit: bvalid=%b stb=%b reg_out=%h, required 1 1000 %h",
                              bus.S_AXI_BVALID, reg_wr_stb, reg_out, model_out());
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(bus.S_AXI_BVALID && !bus.S_AXI_AWREADY && !bus.S_AXI_WREADY && bus.S_AXI_BRESP == 2'b00)) bad++;
            @(negedge ACLK);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL b_hold: %0d bad cycles, required 0 (BVALID held, READY low)", bad);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_BREADY = 1'b0;
        n_cmp++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b011) begin
            n_err++; $display("FAIL b_release: bvalid=%b awready=%b wready=%b, required 0 1 1",
                              bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
        end
    endtask

    task automatic test_invalid();
        bit ok; int lat; logic [1:0] resp; logic [3:0] sb, sa; logic [127:0] ro; logic bva, rva;
        logic [31:0] rd;
        do_write(5'h12, 32'hDEADBEEF, 4'hF, ok, lat, resp, sb, ro, sa, bva);
        n_cmp++;
        if ({ok, resp, sb, ro} !== {1'b1, 2'b10, 4'b0000, model_out()}) begin
            n_err++; $display("FAIL invalid_write: resp=%b stb=%b reg_out=%h, required 10 0000 %h", resp, sb, ro, model_out());
        end
        do_read(5'h14, ok, lat, rd, resp, rva);
        n_cmp++;
        if ({ok, rd, resp} !== {1'b1, 32'h0, 2'b10}) begin
            n_err++; $display("FAIL invalid_read: rdata=%h resp=%b, required 00000000 10", rd, resp);
        end
    endtask

    task automatic test_collision();
        bit ok; int lat; logic [1:0] resp; logic [31:0] rd, old; logic rva;
        old = m[2];
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_WDATA = 32'h99; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_ARADDR = 5'h08; bus.S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_ARVALID = 1'b0;
        model_write(5'h08, 32'h99, 4'hF);
        n_cmp++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_BVALID} !== {1'b1, old, 1'b1}) begin
            n_err++; $display("FAIL collision_old_data: rvalid=%b rdata=%h bvalid=%b, required 1 %h 1",
                              bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_BVALID, old);
        end
        bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
        do_read(5'h08, ok, lat, rd, resp, rva);
        n_cmp++;
        if ({ok, rd, resp} !== {1'b1, 32'h99, 2'b00}) begin
            n_err++; $display("FAIL collision_new_data: rdata=%h resp=%b, required 00000099 00", rd, resp);
        end
    endtask

    task automatic test_back_to_back();
        int hs, bad;
        hs = 0; bad = 0;
        bus.S_AXI_ARADDR = 5'h0C; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (bus.S_AXI_RVALID) begin
                hs++;
                if (bus.S_AXI_RDATA !== m[3]) bad++;
            end
        end
        bus.S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        bus.S_AXI_RREADY = 1'b0;
        n_cmp++;
        if (hs !== 5 || bad !== 0) begin
            n_err++; $display("FAIL back_to_back_reads: %0d reads (%0d bad data) in 10 cycles, required 5 reads of %h", hs, bad, m[3]);
        end
    endtask

    task automatic test_random();
        bit ok; int lat; logic [1:0] resp; logic [3:0] sb, sa; logic [127:0] ro; logic bva, rva;
        logic [31:0] rd, d; logic [4:0] a; logic [3:0] s;
        for (int i = 0; i < 60; i++) begin
            a = 5'($urandom_range(0, 31)); d = $urandom; s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, d, s, ok, lat, resp, sb, ro, sa, bva);
                model_write(a, d, s);
                n_cmp++;
                if ({ok, lat, resp, sb, ro, sa} !== {1'b1, 32'sd1, exp_resp(a), exp_stb(a), model_out(), 4'b0000}) begin
                    n_err++;
                    $display("FAIL rand_write[%0d] a=%h d=%h s=%b: ok=%b lat=%0d resp=%b stb=%b reg_out=%h, required lat=1 resp=%b stb=%b reg_out=%h",
                             i, a, d, s, ok, lat, resp, sb, ro, exp_resp(a), exp_stb(a), model_out());
                end
            end else begin
                do_read(a, ok, lat, rd, resp, rva);
                n_cmp++;
                if ({ok, lat, rd, resp, rva} !== {1'b1, 32'sd0, exp_rdata(a), exp_resp(a), 1'b0}) begin
                    n_err++;
                    $display("FAIL rand_read[%0d] a=%h: ok=%b lat=%0d rdata=%h resp=%b, required rdata=%h resp=%b",
                             i, a, ok, lat, rd, resp, exp_rdata(a), exp_resp(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        // Leave a read response and a write response pending, then reset.
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = 5'h00; bus.S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_WDATA = 32'h5555AAAA; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b11) begin
            n_err++; $display("FAIL reset_mid_setup: bvalid=%b rvalid=%b, required 1 1", bus.S_AXI_BVALID, bus.S_AXI_RVALID);
        end
        ARESET = 1'b1;
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        @(negedge ACLK);
        n_cmp++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, reg_out, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== '0) begin
            n_err++; $display("FAIL reset_mid_clear: bvalid=%b rvalid=%b reg_out=%h, required all 0",
                              bus.S_AXI_BVALID, bus.S_AXI_RVALID, reg_out);
        end
        ARESET = 1'b0;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
            n_err++; $display("FAIL reset_mid_ready_hold: ready=%b%b%b, required 000",
                              bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY);
        end
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.S_AXI_BVALID || bus.S_AXI_RVALID) stale++;
            @(negedge ACLK);
        end
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        n_cmp++;
        if (stale !== 0 || {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL reset_mid_no_stale: %0d stale response cycles ready=%b%b%b, required 0 and 111",
                              stale, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY);
        end
        // A held AW must be discarded by reset: a later lone W must not commit.
        bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        bus.S_AXI_WDATA = 32'h0BADF00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_WVALID = 1'b0;
        stale = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.S_AXI_BVALID || reg_wr_stb != 4'b0) stale++;
            @(negedge ACLK);
        end
        n_cmp++;
        if (stale !== 0 || reg_out !== model_out()) begin
            n_err++; $display("FAIL reset_aw_discard: %0d commit cycles reg_out=%h, required 0 and %h", stale, reg_out, model_out());
        end
        // Completing with an AW now pairs it with the buffered W.
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        model_write(5'h08, 32'h0BADF00D, 4'hF);
        @(negedge ACLK);
        n_cmp++;
        if ({bus.S_AXI_BVALID, reg_wr_stb, reg_out} !== {1'b1, 4'b0100, model_out()}) begin
            n_err++; $display("FAIL reset_w_pair: bvalid=%b stb=%b reg_out=%h, required 1 0100 %h",
                              bus.S_AXI_BVALID, reg_wr_stb, reg_out, model_out());
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq_writes();
        test_strobe();
        test_w_before_aw();
        test_invalid();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
